// File: rtl/gol_gen_sequencer.sv
// Game of Life generation sequencer: host board load, in-place generation sweeps
// with deferred row writeback, and optional per-generation board dump.
module gol_gen_sequencer #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int GENBITS = 16
) (
   input  logic               ph1,
   input  logic               reset,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [WIDTH-1:0]   load_data,
   output logic               load_ready,
   input  logic               run_start,
   input  logic [GENBITS-1:0] n_gens,
   input  logic               dump_en,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [GENBITS-1:0] gen_cnt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [REGBITS-1:0] out_idx,
   output logic               rf_regwrite,
   output logic [REGBITS-1:0] rf_ra,
   output logic [WIDTH-1:0]   rf_wd,
   input  logic [WIDTH-1:0]   rf_row,
   input  logic [WIDTH-1:0]   next_row
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_ACC, S_LOAD_WR, S_GEN, S_DUMP, S_DONE
   } state_t;

   localparam logic [REGBITS-1:0] ROW_ONE    = {{(REGBITS-1){1'b0}}, 1'b1};
   localparam logic [REGBITS-1:0] ROW_LAST   = {REGBITS{1'b1}};
   localparam logic [REGBITS:0]   STEP_ONE   = {{REGBITS{1'b0}}, 1'b1};
   localparam logic [REGBITS:0]   STEP_THREE = {{(REGBITS-1){1'b0}}, 2'b11};
   localparam logic [REGBITS:0]   STEP_W0    = {(REGBITS+1){1'b1}};
   localparam logic [REGBITS:0]   STEP_WLAST = {{REGBITS{1'b1}}, 1'b0};
   localparam logic [GENBITS-1:0] GEN_ONE    = {{(GENBITS-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [REGBITS:0]     step_q, step_d;
   logic [REGBITS-1:0]   load_idx_q, load_idx_d;
   logic [REGBITS-1:0]   out_idx_q, out_idx_d;
   logic [WIDTH-1:0]     stage_q, stage_d;
   logic [WIDTH-1:0]     hold0_q, hold0_d;
   logic [WIDTH-1:0]     pend_q, pend_d;
   logic [WIDTH-1:0]     cur_q, cur_d;
   logic [GENBITS-1:0]   n_gens_q, n_gens_d;
   logic [GENBITS-1:0]   gen_cnt_q, gen_cnt_d;
   logic                 dump_en_q, dump_en_d;
   logic                 abort_q, abort_d;
   logic [REGBITS-1:0]   half;

   assign half    = step_q[REGBITS:1];
   assign busy    = (state_q != S_IDLE);
   assign gen_cnt = gen_cnt_q;
   assign out_idx = out_idx_q;

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      load_idx_d  = load_idx_q;
      out_idx_d   = out_idx_q;
      stage_d     = stage_q;
      hold0_d     = hold0_q;
      pend_d      = pend_q;
      cur_d       = cur_q;
      n_gens_d    = n_gens_q;
      gen_cnt_d   = gen_cnt_q;
      dump_en_d   = dump_en_q;
      abort_d     = abort_q | ((state_q != S_IDLE) & abort);
      load_ready  = 1'b0;
      done        = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      rf_regwrite = 1'b0;
      rf_ra       = '0;
      rf_wd       = '0;

      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d    = S_LOAD_ACC;
               load_idx_d = '0;
            end else if (run_start) begin
               n_gens_d  = n_gens;
               dump_en_d = dump_en;
               gen_cnt_d = '0;
               abort_d   = 1'b0;
               step_d    = '0;
               out_idx_d = '0;
               state_d   = (n_gens == '0) ? S_DONE : S_GEN;
            end
         end
         S_LOAD_ACC: begin
            load_ready = 1'b1;
            if (load_valid) begin
               stage_d = load_data;
               state_d = S_LOAD_WR;
            end
         end
         S_LOAD_WR: begin
            rf_regwrite = 1'b1;
            rf_ra       = load_idx_q;
            rf_wd       = stage_q;
            load_idx_d  = load_idx_q + ROW_ONE;
            state_d     = (load_idx_q == ROW_LAST) ? S_IDLE : S_LOAD_ACC;
         end
         S_GEN: begin
            // Schedule: C0 C1 C2 W1 C3 W2 ... C(N-1) W(N-2) W(N-1) W0; row k is
            // written one step after row k+1 has been read.
            step_d = step_q + STEP_ONE;
            if (step_q == STEP_W0) begin
               rf_regwrite = 1'b1;
               rf_wd       = hold0_q;
               gen_cnt_d   = gen_cnt_q + GEN_ONE;
               if (dump_en_q)
                  state_d = S_DUMP;
               else if (gen_cnt_d == n_gens_q || abort_q)
                  state_d = S_DONE;
            end else if (step_q == STEP_WLAST) begin
               rf_regwrite = 1'b1;
               rf_ra       = ROW_LAST;
               rf_wd       = pend_q;
            end else if (step_q < STEP_THREE || !step_q[0]) begin
               rf_ra = (step_q < STEP_THREE) ? step_q[REGBITS-1:0] : half + ROW_ONE;
               if (rf_ra == '0)
                  hold0_d = next_row;
               else if (rf_ra == ROW_ONE)
                  pend_d = next_row;
               else
                  cur_d = next_row;
            end else begin
               rf_regwrite = 1'b1;
               rf_ra       = half;
               rf_wd       = pend_q;
               pend_d      = cur_q;
            end
         end
         S_DUMP: begin
            out_valid = 1'b1;
            rf_ra     = out_idx_q;
            out_data  = rf_row;
            if (out_ready) begin
               out_idx_d = out_idx_q + ROW_ONE;
               if (out_idx_q == ROW_LAST)
                  state_d = (gen_cnt_q == n_gens_q || abort_q) ? S_DONE : S_GEN;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         step_q     <= '0;
         load_idx_q <= '0;
         out_idx_q  <= '0;
         stage_q    <= '0;
         hold0_q    <= '0;
         pend_q     <= '0;
         cur_q      <= '0;
         n_gens_q   <= '0;
         gen_cnt_q  <= '0;
         dump_en_q  <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         load_idx_q <= load_idx_d;
         out_idx_q  <= out_idx_d;
         stage_q    <= stage_d;
         hold0_q    <= hold0_d;
         pend_q     <= pend_d;
         cur_q      <= cur_d;
         n_gens_q   <= n_gens_d;
         gen_cnt_q  <= gen_cnt_d;
         dump_en_q  <= dump_en_d;
         abort_q    <= abort_d;
      end
   end

endmodule

// File: doc/gol_gen_sequencer.md
Name: gol_gen_sequencer

Overview:
- Sequences the prev_state row register file through Game of Life generations.
- Handles the host load of the initial board and runs N generations in place.
- Defers every writeback so no row is overwritten while a neighbour still reads it; optionally streams the board out after each generation.
- Sits between host/display logic, the prev_state register file and the combinational next-row logic.

Parameters:
WIDTH, 8, cells per row (row word width)
REGBITS, 3, row address bits; rows N = 2**REGBITS, N >= 4
GENBITS, 16, width of generation count/counter

Ports:
ph1  input  1  single clock; all flops on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
load_start  input  1  begin loading N rows (IDLE only)
load_valid  input  1  load_data valid
load_data  input  WIDTH  row word, rows delivered 0..N-1
load_ready  output  1  sequencer accepts a load word
run_start  input  1  begin run (IDLE only); samples n_gens, dump_en
n_gens  input  GENBITS  generations to compute
dump_en  input  1  stream board after each generation
abort  input  1  stop run at next generation boundary
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when run ends
gen_cnt  output  GENBITS  completed generations of current/last run
out_valid  output  1  dump word valid
out_ready  input  1  dump consumer ready
out_data  output  WIDTH  dumped row (= rf_row)
out_idx  output  REGBITS  index of dumped row
rf_regwrite  output  1  to prev_state regwrite
rf_ra  output  REGBITS  to prev_state ra
rf_wd  output  WIDTH  to prev_state wd
rf_row  input  WIDTH  from prev_state row
next_row  input  WIDTH  next-generation value of row rf_ra (from next-row logic)

Behaviour:
- Reset: state IDLE; every output 0; all counters, buffers, abort flag cleared. Reset mid-run leaves register file contents partially updated; no recovery needed.
- rf_regwrite, rf_ra and rf_wd are driven only from flops/state decode, never combinationally from inputs. They are stable for the whole ph1 cycle for the ph2 latch.
- IDLE:
  - load_start -> LOAD_ACC. Else run_start -> RUN (load wins if both are high).
  - Starts while busy are ignored.
- LOAD_ACC: load_ready=1. On load_valid, capture load_data into stage and go to LOAD_WR.
- LOAD_WR: rf_regwrite=1, rf_ra=load idx, rf_wd=stage, load_ready=0. Idx+1; after row N-1 -> IDLE, else LOAD_ACC. Peak rate is 1 row per 2 cycles.
- RUN entry:
  - gen_cnt<=0; latch n_gens, dump_en.
  - If n_gens==0: done pulses the next cycle, no rf writes, return to IDLE.
- Generation schedule for N rows, one cycle per step, exactly 2N cycles:
  - Order: C0, C1, C2, W1, C3, W2, ..., C(N-1), W(N-2), W(N-1), W0.
  - Cr: rf_ra=r, rf_regwrite=0. next_row is captured into hold0 (r=0), pend (r=1) or cur (r>=2).
  - Wk for k=1..N-2: rf_ra=k, rf_regwrite=1, rf_wd=pend; pend<=cur at end.
  - W(N-1): rf_wd=pend. W0: rf_wd=hold0.
  - Invariant: row k is written only after rows k-1, k, k+1 (mod N) have all been read, including the wrap of row 0 and row N-1.
- Generation end:
  - gen_cnt increments in the W0 cycle.
  - If dump_en: DUMP. Else, if gen_cnt==n_gens or abort flag set: DONE, else next C0.
- DUMP:
  - rf_ra=out_idx (registered), out_valid=1, out_data=rf_row.
  - out_data and out_idx are held stable while out_valid & !out_ready.
  - Each handshake increments out_idx. After row N-1, apply the same done/next test as generation end.
- DONE: one cycle, done=1 -> IDLE. gen_cnt holds until the next run_start.
- abort: sampled any busy cycle into a sticky flag, cleared on run_start. It takes effect only at a generation/dump boundary, so the current generation always completes.
- Counters wrap mod 2**REGBITS on the row index. gen_cnt never exceeds the latched n_gens.

Test Plan:
- Assert reset low mid-run -> all outputs 0 immediately; after release, busy=0, IDLE.
- load_start, then 8 rows 0x00,0x00,0x08,0x04,0x1C,0,0,0 with load_valid held high -> rf_regwrite on every 2nd cycle at rf_ra 0..7 with matching rf_wd; load_ready low on write cycles.
- Vertical blinker: rows 2-4=0x08, reference next-row model, run n_gens=1 -> rf_ra sequence 0,1,2,1,3,2,4,3,5,4,6,5,7,6,7,0 with regwrite pattern 0,0,0,1,0,1,...,1,1,1. Result: row 3=0x1C, rows 2 and 4=0x00. done after 16+1 cycles; gen_cnt=1.
- n_gens=0 -> done one cycle after run_start, rf_regwrite never asserted, gen_cnt=0.
- n_gens=2, dump_en=1, out_ready toggling 1,0,0,1 -> 8 dump words per generation, out_idx 0..7 in order, out_data stable while stalled; board returns to the initial blinker.
- n_gens=10, abort pulsed during generation 3 -> generation 3 completes all 16 steps; done pulses; gen_cnt=3.
